// File: rtl/kernel_conv_engine_if.sv
// kernel_conv_engine_if: kernel-programming port, frame control and the
// pixel input/output streams of the convolution engine.
// master = processor / stream side, slave = engine.
interface kernel_conv_engine_if #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int SEL_W  = 2,
    parameter int IDX_W  = 4
);
    logic              coef_we;
    logic              norm_we;
    logic [SEL_W-1:0]  coef_sel;
    logic [IDX_W-1:0]  coef_idx;
    logic [COEF_W-1:0] coef_data;
    logic [SEL_W-1:0]  krn_sel;
    logic              start;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_last;
    logic              frame_done;

    modport master (
        output coef_we, norm_we, coef_sel, coef_idx, coef_data, krn_sel, start,
        output in_valid, in_pixel, out_ready,
        input  busy, in_ready, out_valid, out_pixel, out_last, frame_done
    );

    modport slave (
        input  coef_we, norm_we, coef_sel, coef_idx, coef_data, krn_sel, start,
        input  in_valid, in_pixel, out_ready,
        output busy, in_ready, out_valid, out_pixel, out_last, frame_done
    );
endinterface

// File: rtl/kernel_conv_engine.sv
// kernel_conv_engine: streaming KxK 2-D convolution over one IMG_W x IMG_H
// frame, using a bank of NUM_KRN programmable signed kernels with per-kernel
// normalisation shift. Only valid-region pixels are emitted.
// Optional build macro KRN_ABS_EN: negative normalised results are replaced by
// their magnitude instead of clamping to zero.
module kernel_conv_engine #(
    parameter int PIX_W   = 8,
    parameter int COEF_W  = 8,
    parameter int K       = 3,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int NUM_KRN = 4
) (
    input  logic                clk,
    input  logic                rst,
    kernel_conv_engine_if.slave bus_if
);
    localparam int KK     = K * K;
    localparam int CTR    = KK / 2;
    localparam int SEL_W  = (NUM_KRN > 1) ? $clog2(NUM_KRN) : 1;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PROD_W = COEF_W + PIX_W + 1;
    localparam int ACC_W  = PIX_W + COEF_W + $clog2(KK) + 1;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [SEL_W-1:0] krn_q;

    logic signed [COEF_W-1:0] coef_q  [NUM_KRN][KK];
    logic [3:0]               shift_q [NUM_KRN];

    logic [PIX_W-1:0] linebuf [K-1][IMG_W];
    logic [PIX_W-1:0] col_vec [K];

    logic [PIX_W-1:0]         win_p0 [K][K];
    logic                     vld_p0, last_p0;
    logic signed [PROD_W-1:0] prod_p1 [KK];
    logic                     vld_p1, last_p1;
    logic signed [ACC_W-1:0]  acc_p1;
    logic [PIX_W-1:0]         result_p1;
    logic [PIX_W-1:0]         out_pixel_q;
    logic                     out_valid_q, out_last_q;

    logic stall, run_ready, hs, at_col_end, at_row_end, last_px, in_region;
    logic sel_ok, idx_ok;

    // Signed coefficient times zero-extended pixel, both widened before multiply.
    function automatic logic signed [PROD_W-1:0] mul_px(input logic signed [COEF_W-1:0] c,
                                                        input logic [PIX_W-1:0] p);
        logic signed [PROD_W-1:0] ce, pe;
        ce = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
        pe = {{(PROD_W-PIX_W){1'b0}}, p};
        return ce * pe;
    endfunction

    // Map a normalised sum onto the unsigned pixel range.
    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] m;
        m = v;
`ifdef KRN_ABS_EN
        if (v < 0) m = -v;
`else
        if (v < 0) m = '0;
`endif
        if (m > PIX_MAX) return '1;
        return m[PIX_W-1:0];
    endfunction

    assign stall      = out_valid_q & ~bus_if.out_ready;
    assign run_ready  = (state_q == RUN) & ~stall;
    assign hs         = bus_if.in_valid & run_ready;
    assign at_col_end = (col_q == CW'(IMG_W - 1));
    assign at_row_end = (row_q == RW'(IMG_H - 1));
    assign last_px    = at_col_end & at_row_end;
    assign in_region  = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);
    assign sel_ok     = int'(bus_if.coef_sel) < NUM_KRN;
    assign idx_ok     = int'(bus_if.coef_idx) < KK;

    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_pixel = out_pixel_q;
    assign bus_if.out_last  = out_last_q;

    // Frame FSM: next state and control outputs.
    always_comb begin
        state_d           = state_q;
        bus_if.in_ready   = 1'b0;
        bus_if.busy       = 1'b0;
        bus_if.frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus_if.start) state_d = RUN;
            end
            RUN: begin
                bus_if.in_ready = run_ready;
                bus_if.busy     = 1'b1;
                if (hs && last_px) state_d = FLUSH;
            end
            FLUSH: begin
                bus_if.busy = 1'b1;
                // Nothing left behind the output register and it is leaving now.
                if (!vld_p0 && !vld_p1 && (!out_valid_q || bus_if.out_ready)) state_d = DONE;
            end
            DONE: begin
                bus_if.frame_done = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, raster position counters and kernel selection latched at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            krn_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus_if.start) begin
                col_q <= '0;
                row_q <= '0;
                krn_q <= bus_if.krn_sel;
            end else if (hs) begin
                if (at_col_end) begin
                    col_q <= '0;
                    row_q <= at_row_end ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Kernel bank: identity on reset, writable only between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KRN; k++) begin
                for (int i = 0; i < KK; i++) begin
                    coef_q[k][i] <= (i == CTR) ? COEF_W'(1) : '0;
                end
                shift_q[k] <= '0;
            end
        end else if (state_q == IDLE) begin
            if (bus_if.coef_we && sel_ok && idx_ok)
                coef_q[bus_if.coef_sel][bus_if.coef_idx] <= bus_if.coef_data;
            if (bus_if.norm_we && sel_ok)
                shift_q[bus_if.coef_sel] <= bus_if.coef_data[3:0];
        end
    end

    // Current column of the window: stored rows from the line buffers plus the new pixel.
    always_comb begin
        for (int j = 0; j < K - 1; j++) col_vec[j] = linebuf[j][col_q];
        col_vec[K-1] = bus_if.in_pixel;
    end

    // Line buffers: each row slot moves one row older on every accepted pixel.
    always_ff @(posedge clk) begin
        if (hs) begin
            for (int j = 0; j < K - 1; j++) linebuf[j][col_q] <= col_vec[j+1];
        end
    end

    // Stage 0: KxK window slides left by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (hs) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_p0[r][c] <= win_p0[r][c+1];
                win_p0[r][K-1] <= col_vec[r];
            end
        end
    end

    // Stage 1: per-tap products, frozen while the output is stalled.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod_p1[r*K+c] <= mul_px(coef_q[krn_q][r*K+c], win_p0[r][c]);
                end
            end
        end
    end

    // Stage 2 combinational part: adder tree, normalising shift, saturation.
    always_comb begin
        acc_p1 = '0;
        for (int i = 0; i < KK; i++) begin
            acc_p1 = acc_p1 + {{(ACC_W-PROD_W){prod_p1[i][PROD_W-1]}}, prod_p1[i]};
        end
        result_p1 = sat_pix(acc_p1 >>> shift_q[krn_q]);
    end

    // Pipeline valid/last tracking and the output register; all hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            last_p0     <= 1'b0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pixel_q <= '0;
        end else if (!stall) begin
            vld_p0      <= hs & in_region;
            last_p0     <= hs & last_px;
            vld_p1      <= vld_p0;
            last_p1     <= last_p0;
            out_valid_q <= vld_p1;
            out_last_q  <= last_p1;
            if (vld_p1) out_pixel_q <= result_p1;
        end
    end
endmodule

// File: tb/tb_kernel_conv_engine.sv
// Testbench for kernel_conv_engine: 8x6 frames, 3x3 kernels, scoreboard of
// expected output pixels built from a behavioural convolution model.
module tb_kernel_conv_engine;
    localparam int PIX_W = 8;
    localparam int COEF_W = 8;
    localparam int KS = 3;
    localparam int W = 8;
    localparam int H = 6;
    localparam int NK = 4;
    localparam int NOUT = (W - KS + 1) * (H - KS + 1);

    typedef int kern_t [9];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kernel_conv_engine_if #(.PIX_W(PIX_W), .COEF_W(COEF_W), .SEL_W(2), .IDX_W(4)) bus_if ();

    kernel_conv_engine #(
        .PIX_W(PIX_W), .COEF_W(COEF_W), .K(KS), .IMG_W(W), .IMG_H(H), .NUM_KRN(NK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_if(bus_if)
    );

    int    checks = 0;
    int    failures = 0;
    int    img [H][W];
    kern_t mk;
    int    msh;
    int    exp_pix_q [$];
    bit    exp_last_q [$];
    int    got [NOUT];
    int    live_out;

    kern_t IDENT   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    kern_t GAUSS   = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    kern_t SHARPEN = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

    // Behavioural convolution of the window whose bottom-right pixel is (r,c).
    function automatic int ref_pix(int r, int c);
        int s;
        s = 0;
        for (int i = 0; i < KS; i++)
            for (int j = 0; j < KS; j++)
                s += mk[i*KS+j] * img[r-KS+1+i][c-KS+1+j];
        s = s >>> msh;
`ifdef KRN_ABS_EN
        if (s < 0) s = -s;
`else
        if (s < 0) s = 0;
`endif
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic idle_inputs();
        bus_if.coef_we = 0; bus_if.norm_we = 0; bus_if.coef_sel = 0; bus_if.coef_idx = 0;
        bus_if.coef_data = 0; bus_if.krn_sel = 0; bus_if.start = 0;
        bus_if.in_valid = 0; bus_if.in_pixel = 0; bus_if.out_ready = 1;
    endtask

    task automatic load_kernel(input int sel, input kern_t c, input int sh);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            bus_if.coef_we = 1; bus_if.coef_sel = 2'(sel); bus_if.coef_idx = 4'(i);
            bus_if.coef_data = 8'(c[i]);
        end
        @(posedge clk); #1;
        bus_if.coef_we = 0; bus_if.norm_we = 1; bus_if.coef_data = 8'(sh);
        @(posedge clk); #1;
        bus_if.norm_we = 0;
    endtask

    task automatic start_frame(input int sel);
        @(posedge clk); #1;
        bus_if.krn_sel = 2'(sel); bus_if.start = 1;
        @(posedge clk); #1;
        bus_if.start = 0;
        live_out = 0;
    endtask

    // Drives npix raster pixels; pushes the model result for every window-completing pixel.
    task automatic drive_frame(input int npix);
        int n, wd;
        n = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n < npix) begin
                    bus_if.in_valid = 1; bus_if.in_pixel = 8'(img[r][c]);
                    wd = 0;
                    forever begin
                        @(negedge clk);
                        if (bus_if.in_ready) break;
                        wd++;
                        if (wd > 1000) begin
                            $display("FAIL in_ready_timeout got=0 expected=1 pixel=(%0d,%0d)", r, c);
                            $fatal(1, "input never accepted");
                        end
                    end
                    if (r >= KS - 1 && c >= KS - 1) begin
                        exp_pix_q.push_back(ref_pix(r, c));
                        exp_last_q.push_back(r == H - 1 && c == W - 1);
                    end
                    @(posedge clk); #1;
                    n++;
                end
            end
        end
        bus_if.in_valid = 0;
    endtask

    // Scoreboard side: pops and compares on each output handshake until frame_done.
    task automatic collect(output int nout, output int gap, output bit busy_d, output bit done_ok);
        int ep, last_hs;
        bit el;
        nout = 0; gap = -1; busy_d = 1; done_ok = 0; last_hs = -100;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (bus_if.out_valid && bus_if.out_ready) begin
                checks++;
                if (exp_pix_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%0d expected=none", bus_if.out_pixel);
                end else begin
                    ep = exp_pix_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (bus_if.out_pixel !== 8'(ep)) begin
                        failures++;
                        $display("FAIL out_pixel[%0d] got=%0d expected=%0d", nout, bus_if.out_pixel, ep);
                    end
                    checks++;
                    if (bus_if.out_last !== el) begin
                        failures++;
                        $display("FAIL out_last[%0d] got=%0b expected=%0b", nout, bus_if.out_last, el);
                    end
                end
                if (nout < NOUT) got[nout] = int'(bus_if.out_pixel);
                nout++;
                live_out = nout;
                last_hs = t;
            end
            if (bus_if.frame_done) begin
                done_ok = 1; gap = t - last_hs; busy_d = bus_if.busy;
                break;
            end
        end
    endtask

    task automatic run_frame(input int sel, output int nout, output int gap,
                             output bit busy_d, output bit done_ok);
        start_frame(sel);
        fork
            drive_frame(W * H);
            collect(nout, gap, busy_d, done_ok);
        join
        @(posedge clk); #1;
    endtask

    task automatic check_frame_end(input string name, input int nout, input int gap,
                                   input bit busy_d, input bit done_ok);
        checks++;
        if (nout !== NOUT) begin failures++; $display("FAIL %s_count got=%0d expected=%0d", name, nout, NOUT); end
        checks++;
        if (done_ok !== 1'b1 || gap !== 1) begin
            failures++; $display("FAIL %s_frame_done got=seen%0b/gap%0d expected=seen1/gap1", name, done_ok, gap);
        end
        checks++;
        if (busy_d !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%0b expected=0", name, busy_d); end
        checks++;
        if (exp_pix_q.size() !== 0) begin
            failures++; $display("FAIL %s_leftover got=%0d expected=0", name, exp_pix_q.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.busy, bus_if.in_ready, bus_if.out_valid, bus_if.out_last, bus_if.frame_done, bus_if.out_pixel} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0b%0b%0b%0b%0b/%0d expected=00000/0", bus_if.busy, bus_if.in_ready,
                     bus_if.out_valid, bus_if.out_last, bus_if.frame_done, bus_if.out_pixel);
        end
        rst = 0;
        bus_if.in_valid = 1; bus_if.in_pixel = 8'd77;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus_if.in_ready !== 1'b0 || bus_if.busy !== 1'b0) begin
                failures++; $display("FAIL idle_in_ready got=%0b/%0b expected=0/0", bus_if.in_ready, bus_if.busy);
            end
        end
        @(posedge clk); #1;
        bus_if.in_valid = 0;
    endtask

    task automatic test_identity(input int sel, input string name);
        int nout, gap; bit busy_d, done_ok;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r * 8 + c;
        mk = IDENT; msh = 0;
        run_frame(sel, nout, gap, busy_d, done_ok);
        check_frame_end(name, nout, gap, busy_d, done_ok);
        checks++;
        if (got[0] !== 9 || got[NOUT-1] !== 38) begin
            failures++; $display("FAIL %s_ends got=%0d/%0d expected=9/38", name, got[0], got[NOUT-1]);
        end
    endtask

    task automatic test_gauss();
        int nout, gap, bad; bit busy_d, done_ok;
        load_kernel(1, GAUSS, 4);
        mk = GAUSS; msh = 4;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
        run_frame(1, nout, gap, busy_d, done_ok);
        check_frame_end("gauss", nout, gap, busy_d, done_ok);
        bad = 0;
        for (int i = 0; i < NOUT; i++) if (got[i] != 100) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL gauss_const got=%0d_off expected=0_off", bad); end
    endtask

    task automatic test_sharpen();
        int nout, gap, nb; bit busy_d, done_ok;
        load_kernel(2, SHARPEN, 0);
        mk = SHARPEN; msh = 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
        img[2][2] = 255;
        run_frame(2, nout, gap, busy_d, done_ok);
        check_frame_end("sharpen", nout, gap, busy_d, done_ok);
        checks++;
        if (got[7] !== 255) begin failures++; $display("FAIL sharpen_centre got=%0d expected=255", got[7]); end
`ifdef KRN_ABS_EN
        nb = 255;
`else
        nb = 0;
`endif
        checks++;
        if (got[1] !== nb || got[6] !== nb || got[8] !== nb || got[13] !== nb) begin
            failures++;
            $display("FAIL sharpen_neigh got=%0d/%0d/%0d/%0d expected=%0d", got[1], got[6], got[8], got[13], nb);
        end
    endtask

    task automatic test_stall();
        int nout, gap, hp; bit busy_d, done_ok, seen, hl;
        mk = GAUSS; msh = 4;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
        seen = 0; hp = 0; hl = 0;
        start_frame(1);
        fork
            drive_frame(W * H);
            collect(nout, gap, busy_d, done_ok);
            begin
                for (int t = 0; t < 2000 && live_out < 5; t++) @(negedge clk);
                @(posedge clk); #1;
                bus_if.out_ready = 0;
                for (int t = 0; t < 10; t++) begin
                    @(negedge clk);
                    if (seen) begin
                        checks++;
                        if (bus_if.out_valid !== 1'b1 || bus_if.out_pixel !== 8'(hp) || bus_if.out_last !== hl) begin
                            failures++;
                            $display("FAIL stall_hold got=%0b/%0d expected=1/%0d", bus_if.out_valid, bus_if.out_pixel, hp);
                        end
                        checks++;
                        if (bus_if.in_ready !== 1'b0) begin
                            failures++; $display("FAIL stall_in_ready got=%0b expected=0", bus_if.in_ready);
                        end
                    end else if (bus_if.out_valid) begin
                        seen = 1; hp = int'(bus_if.out_pixel); hl = bus_if.out_last;
                    end
                end
                @(posedge clk); #1;
                bus_if.out_ready = 1;
            end
        join
        @(posedge clk); #1;
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL stall_engaged got=0 expected=1"); end
        check_frame_end("stall", nout, gap, busy_d, done_ok);
    endtask

    task automatic test_run_write();
        int nout, gap; bit busy_d, done_ok;
        mk = GAUSS; msh = 4;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
        start_frame(1);
        fork
            drive_frame(W * H);
            collect(nout, gap, busy_d, done_ok);
            begin
                repeat (10) @(posedge clk);
                #1;
                bus_if.coef_we = 1; bus_if.norm_we = 1; bus_if.coef_sel = 2'd1;
                bus_if.coef_idx = 4'd4; bus_if.coef_data = 8'd0;
                bus_if.start = 1; bus_if.krn_sel = 2'd0;
                @(posedge clk); #1;
                bus_if.coef_we = 0; bus_if.norm_we = 0; bus_if.start = 0;
            end
        join
        @(posedge clk); #1;
        check_frame_end("runwr", nout, gap, busy_d, done_ok);
        // Same write in IDLE: coefficient 2 and shift 2 in one cycle.
        bus_if.coef_we = 1; bus_if.norm_we = 1; bus_if.coef_sel = 2'd1;
        bus_if.coef_idx = 4'd4; bus_if.coef_data = 8'd2;
        @(posedge clk); #1;
        bus_if.coef_we = 0; bus_if.norm_we = 0;
        mk[4] = 2; msh = 2;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 63));
        run_frame(1, nout, gap, busy_d, done_ok);
        check_frame_end("idlewr", nout, gap, busy_d, done_ok);
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r * 8 + c;
        mk = GAUSS; msh = 4;
        start_frame(1);
        drive_frame(20);
        #2 rst = 1;
        #1;
        checks++;
        if ({bus_if.busy, bus_if.in_ready, bus_if.out_valid, bus_if.out_last, bus_if.frame_done, bus_if.out_pixel} !== 13'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%0b%0b%0b%0b%0b/%0d expected=00000/0", bus_if.busy, bus_if.in_ready,
                     bus_if.out_valid, bus_if.out_last, bus_if.frame_done, bus_if.out_pixel);
        end
        exp_pix_q.delete();
        exp_last_q.delete();
        @(posedge clk); #1;
        rst = 0;
        // Kernel 1 must be back to identity after reset.
        test_identity(1, "postrst");
    endtask

    initial begin
        test_reset();
        test_identity(0, "ident");
        test_gauss();
        test_sharpen();
        test_stall();
        test_run_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
